sensor_hit_tracker: RTL
=======================

SENSOR_HIT_TRACKER -- requirements
Module: sensor_hit_tracker

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, sets the stable-sample count before a sensor code is accepted (10 ms at 50 MHz).
REQ-002 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 box_address  in  3  raw sensor code from the sensor-read stage; 0 = no contact, 1..7 = struck box; asynchronous to CLOCK_50.
REQ-005 target_box  in  3  box currently lit by the game FSM.
REQ-006 target_valid  in  1  high while target_box is live.
REQ-007 hit_valid  out  1  a debounced hit event is pending.
REQ-008 hit_box  out  3  box index of the pending event.
REQ-009 hit_match  out  1  the pending event struck the live target.
REQ-010 hit_ready  in  1  consumer accepts the event when hit_valid and hit_ready are both high at a rising edge.
REQ-011 score_bcd  out  8  two-digit BCD count of matching hits, {tens, ones}.
REQ-012 miss_count  out  4  count of non-matching hits.
REQ-013 overrun  out  1  sticky; a hit was dropped because an event was still pending.

Function
REQ-014 box_address shall pass through a two-flop synchronizer before any other use.
REQ-015 Debounce: synced code differing from the candidate register reloads the candidate and clears the counter; an equal code increments the counter; at DEBOUNCE_CYCLES-1 the candidate becomes the stable code.
REQ-016 FSM states: IDLE (stable code 0), WAIT_RELEASE (stable code nonzero, event already issued).
REQ-017 IDLE -> WAIT_RELEASE on the stable code changing from 0 to nonzero; this cycle is the "strike".
REQ-018 WAIT_RELEASE -> IDLE only when the stable code returns to 0; nonzero-to-nonzero changes are ignored and generate no event.
REQ-019 On a strike, hit_box = stable code and hit_match = target_valid AND (target_box == stable code), both sampled in the strike cycle; hit_valid rises on the next edge.
REQ-020 Latency: hit_valid is high exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples a new stable box_address from a settled 0.
REQ-021 hit_valid, hit_box and hit_match shall hold constant until accepted; hit_valid drops on the edge after acceptance unless a new strike loads the slot on that same edge.
REQ-022 A strike while hit_valid is high and hit_ready is low shall be dropped (outputs unchanged, counters unchanged) and shall set overrun.
REQ-023 A strike coinciding with acceptance shall load the new event; overrun is not set.
REQ-024 score_bcd increments in BCD on each loaded matching event (09 -> 10); it saturates at 99.
REQ-025 miss_count increments on each loaded non-matching event; it saturates at 15.
REQ-026 Changes on target_box and target_valid after the strike cycle shall not alter a pending event.

Reset
REQ-027 While reset is high: synchronizer, candidate, stable code and counter = 0; FSM = IDLE; hit_valid = 0, hit_box = 0, hit_match = 0, score_bcd = 8'h00, miss_count = 0, overrun = 0.
REQ-028 A reset asserted mid-debounce or with an event pending discards all in-flight state; no event is issued after release until a fresh 0 -> nonzero stable transition.

Structure
REQ-029 Shared package bytebasher_pkg shall hold BOX_W = 3, BOX_NONE = 3'd0, the DEBOUNCE_CYCLES default, and SCORE_MAX_BCD = 8'h99.
REQ-030 Synchronizer plus debounce shall be one sub-module, sensor_debounce, instantiated once; the FSM, event slot and counters live in the top module.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 box_address 0 -> 3, target_box = 3, target_valid = 1, hit_ready = 1 -> hit_valid high for 1 cycle, 7 edges after the change; hit_box = 3, hit_match = 1, score_bcd = 8'h01.
REQ-032 box_address toggles 0/5 every 2 cycles for 20 cycles, then holds 0 -> no hit_valid; counters stay 0.
REQ-033 hit_ready = 0; strike box 2, release, strike box 4 -> hit_box stays 2; overrun = 1; miss_count = 1 only.
REQ-034 Start from score_bcd = 8'h98; two matching strikes -> 8'h99, then saturates at 8'h99 on the next; a 9th matching hit from 8'h08 gives 8'h09 -> 8'h10.
REQ-035 box_address 0 -> 6 -> 1 with no release -> exactly one event with hit_box = 6.
REQ-036 reset pulse 2 cycles after the strike with hit_ready = 0 -> all outputs 0; holding box_address = 6 afterwards yields no event until it returns to 0 and strikes again.

Source files
------------

// File: rtl/bytebasher_pkg.sv
// rtl/bytebasher_pkg.sv - shared box-code widths, debounce default, score limits and BCD helper
package bytebasher_pkg;

  localparam int              BOX_W                   = 3;
  localparam logic [BOX_W-1:0] BOX_NONE               = 3'd0;
  localparam int              DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam logic [7:0]      SCORE_MAX_BCD           = 8'h99;
  localparam logic [3:0]      MISS_MAX                = 4'd15;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_RELEASE
  } hit_state_t;

  // Two-digit BCD increment that holds at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == SCORE_MAX_BCD)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchronizer followed by a stable-count debouncer
module sensor_debounce
  import bytebasher_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BOX_W-1:0] raw_code,
  output logic [BOX_W-1:0] stable_code,
  output logic             settled
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The stable register loads on the edge the counter reaches CNT_LAST.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [BOX_W-1:0] sync1;
  logic [BOX_W-1:0] sync2;
  logic [BOX_W-1:0] candidate;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= BOX_NONE;
      sync2       <= BOX_NONE;
      candidate   <= BOX_NONE;
      count       <= '0;
      stable_code <= BOX_NONE;
      settled     <= 1'b0;
    end else begin
      sync1 <= raw_code;
      sync2 <= sync1;
      if (sync2 != candidate) begin
        candidate <= sync2;
        count     <= '0;
        settled   <= 1'b0;
      end else begin
        if (count != CNT_LAST)
          count <= count + 1'b1;
        if (count >= CNT_LOAD) begin
          stable_code <= candidate;
          settled     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sensor_hit_tracker.sv
// rtl/sensor_hit_tracker.sv - strike detection FSM, one-deep hit event slot, score and miss counters
module sensor_hit_tracker
  import bytebasher_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [BOX_W-1:0] box_address,
  input  logic [BOX_W-1:0] target_box,
  input  logic             target_valid,
  output logic             hit_valid,
  output logic [BOX_W-1:0] hit_box,
  output logic             hit_match,
  input  logic             hit_ready,
  output logic [7:0]       score_bcd,
  output logic [3:0]       miss_count,
  output logic             overrun
);

  logic [BOX_W-1:0] stable_code;
  logic             settled;
  hit_state_t       state;
  logic             armed;
  logic             strike;
  logic             slot_free;
  logic             new_match;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (CLOCK_50),
    .rst        (reset),
    .raw_code   (box_address),
    .stable_code(stable_code),
    .settled    (settled)
  );

  // A sensor held through reset must be seen to settle at 0 before it can strike.
  assign strike    = (state == ST_IDLE) && armed && (stable_code != BOX_NONE);
  assign slot_free = !hit_valid || hit_ready;
  assign new_match = target_valid && (target_box == stable_code);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      armed      <= 1'b0;
      hit_valid  <= 1'b0;
      hit_box    <= BOX_NONE;
      hit_match  <= 1'b0;
      score_bcd  <= 8'h00;
      miss_count <= 4'd0;
      overrun    <= 1'b0;
    end else begin
      if (settled && (stable_code == BOX_NONE))
        armed <= 1'b1;

      case (state)
        ST_IDLE:         if (strike) state <= ST_WAIT_RELEASE;
        ST_WAIT_RELEASE: if (stable_code == BOX_NONE) state <= ST_IDLE;
        default:         state <= ST_IDLE;
      endcase

      if (strike && slot_free) begin
        hit_valid <= 1'b1;
        hit_box   <= stable_code;
        hit_match <= new_match;
        if (new_match)
          score_bcd <= bcd_inc_sat(score_bcd);
        else if (miss_count != MISS_MAX)
          miss_count <= miss_count + 4'd1;
      end else begin
        if (strike)
          overrun <= 1'b1;
        if (hit_valid && hit_ready)
          hit_valid <= 1'b0;
      end
    end
  end

endmodule
